// File: rtl/uart_program_loader_if.sv
// Loader-side bundle: UART receive/transmit handshake and SRAM write port.
// master = loader, slave = UART/SRAM environment.
interface uart_program_loader_if #(
    parameter int ADDR_W = 4
);
    // rx_valid is a one-cycle pulse with no back-pressure: the byte is taken that cycle or lost.
    // tx_start is held high until tx_done rises; the loader then drops it and waits for tx_done low.
    logic              rx_valid;
    logic [7:0]        rx_data;
    logic              tx_done;
    logic              tx_start;
    logic [7:0]        tx_data;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;

    modport master (
        input  rx_valid, rx_data, tx_done,
        output tx_start, tx_data, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        output rx_valid, rx_data, tx_done,
        input  tx_start, tx_data, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/uart_program_loader.sv
// Framed UART program loader: buffers SYNC/CNT/ADDR/DATA/CSUM frames, commits to SRAM, replies ACK/NAK.
// Optional inter-byte timeout enabled with `define LOADER_TIMEOUT_EN.
module uart_program_loader #(
    parameter int          MEM_DEPTH      = 16,
    parameter int          ADDR_W         = 4,
    parameter logic [7:0]  SYNC_BYTE      = 8'h55,
    parameter logic [7:0]  ACK_BYTE       = 8'h06,
    parameter logic [7:0]  NAK_BYTE       = 8'h15,
    parameter int          TIMEOUT_CYCLES = 2700000
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst,
    uart_program_loader_if.master bus,
    output logic                  cpu_hold,
    output logic                  load_ok,
    output logic                  load_err,
    output logic [2:0]            dbg_state
);

    typedef enum logic [2:0] {
        IDLE, CNT, ADDR, DATA, CSUM, COMMIT, RESP, RESP_WAIT
    } state_t;

    state_t            state;
    logic [ADDR_W:0]   cnt;
    logic [ADDR_W:0]   idx;
    logic [ADDR_W-1:0] base;
    logic [7:0]        sum;
    logic [7:0]        sum_next;
    logic [7:0]        resp;
    logic              timeout_hit;
    logic [7:0]        buffer [MEM_DEPTH];

    assign sum_next  = sum + bus.rx_data;
    assign dbg_state = state;

`ifdef LOADER_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TO_W-1:0] to_cnt;
    logic            in_frame;

    assign in_frame    = (state == CNT) || (state == ADDR) || (state == DATA) || (state == CSUM);
    assign timeout_hit = in_frame && (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge sys_clk) begin
        if (sys_rst || !in_frame || bus.rx_valid) begin
            to_cnt <= '0;
        end else if (!timeout_hit) begin
            to_cnt <= to_cnt + 1'b1;
        end
    end
`else
    logic unused_timeout;
    assign timeout_hit    = 1'b0;
    assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

    // Payload buffer carries no reset; it is always fully rewritten before a commit reads it.
    always_ff @(posedge sys_clk) begin
        if (state == DATA && bus.rx_valid) begin
            buffer[idx[ADDR_W-1:0]] <= bus.rx_data;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state         <= IDLE;
            cnt           <= '0;
            idx           <= '0;
            base          <= '0;
            sum           <= '0;
            resp          <= '0;
            cpu_hold      <= 1'b0;
            load_ok       <= 1'b0;
            load_err      <= 1'b0;
            bus.tx_start  <= 1'b0;
            bus.tx_data   <= '0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
        end else begin
            load_ok    <= 1'b0;
            load_err   <= 1'b0;
            bus.mem_we <= 1'b0;

            if (timeout_hit && !bus.rx_valid) begin
                resp     <= NAK_BYTE;
                load_err <= 1'b1;
                state    <= RESP;
            end else begin
                case (state)
                    IDLE: begin
                        if (bus.rx_valid && bus.rx_data == SYNC_BYTE) begin
                            cpu_hold <= 1'b1;
                            state    <= CNT;
                        end
                    end
                    CNT: begin
                        if (bus.rx_valid) begin
                            if (bus.rx_data != 8'd0 && bus.rx_data <= 8'(MEM_DEPTH)) begin
                                cnt   <= bus.rx_data[ADDR_W:0];
                                sum   <= bus.rx_data;
                                state <= ADDR;
                            end else begin
                                resp     <= NAK_BYTE;
                                load_err <= 1'b1;
                                state    <= RESP;
                            end
                        end
                    end
                    ADDR: begin
                        if (bus.rx_valid) begin
                            base  <= bus.rx_data[ADDR_W-1:0];
                            sum   <= sum_next;
                            idx   <= '0;
                            state <= DATA;
                        end
                    end
                    DATA: begin
                        if (bus.rx_valid) begin
                            sum <= sum_next;
                            idx <= idx + 1'b1;
                            if (idx == cnt - 1'b1) begin
                                state <= CSUM;
                            end
                        end
                    end
                    CSUM: begin
                        if (bus.rx_valid) begin
                            if (sum_next == 8'd0) begin
                                // Issue write 0 here so it lands the cycle after the checksum byte.
                                bus.mem_we    <= 1'b1;
                                bus.mem_addr  <= base;
                                bus.mem_wdata <= buffer[0];
                                idx           <= {{ADDR_W{1'b0}}, 1'b1};
                                state         <= COMMIT;
                            end else begin
                                resp     <= NAK_BYTE;
                                load_err <= 1'b1;
                                state    <= RESP;
                            end
                        end
                    end
                    COMMIT: begin
                        if (idx == cnt) begin
                            load_ok <= 1'b1;
                            resp    <= ACK_BYTE;
                            state   <= RESP;
                        end else begin
                            bus.mem_we    <= 1'b1;
                            bus.mem_addr  <= base + idx[ADDR_W-1:0];
                            bus.mem_wdata <= buffer[idx[ADDR_W-1:0]];
                            idx           <= idx + 1'b1;
                        end
                    end
                    RESP: begin
                        bus.tx_start <= 1'b1;
                        bus.tx_data  <= resp;
                        state        <= RESP_WAIT;
                    end
                    RESP_WAIT: begin
                        if (bus.tx_start) begin
                            if (bus.tx_done) begin
                                bus.tx_start <= 1'b0;
                            end
                        end else if (!bus.tx_done) begin
                            cpu_hold <= 1'b0;
                            state    <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_program_loader.sv
// Directed bench for uart_program_loader: frame vectors, SRAM write scoreboard, ACK/NAK and reset abort.
module tb_uart_program_loader;

    logic       sys_clk = 1'b0;
    logic       sys_rst = 1'b1;
    logic       cpu_hold;
    logic       load_ok;
    logic       load_err;
    logic [2:0] dbg_state;

    uart_program_loader_if #(.ADDR_W(4)) bus ();

    uart_program_loader #(.MEM_DEPTH(16), .ADDR_W(4)) dut (
        .sys_clk   (sys_clk),
        .sys_rst   (sys_rst),
        .bus       (bus.master),
        .cpu_hold  (cpu_hold),
        .load_ok   (load_ok),
        .load_err  (load_err),
        .dbg_state (dbg_state)
    );

    // clock / cycle counter
    always #5 sys_clk = ~sys_clk;

    int cyc = 0;
    always @(posedge sys_clk) cyc <= cyc + 1;

    // scoreboard state
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [11:0] exp_q[$];
    logic [11:0] wr_q[$];
    int          wr_cyc_q[$];
    int          ok_cnt = 0, err_cnt = 0, tx_cnt = 0;
    int          ok_cyc = 0, hold_fall_cyc = 0, done_fall_cyc = 0;
    logic [7:0]  tx_byte = 8'h00;
    int          last_rx_cyc = 0;
    logic [7:0]  frm[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    // monitor: logs writes, pulses, transmit requests and cpu_hold release
    initial begin
        logic hold_prev = 1'b0;
        logic tx_prev   = 1'b0;
        forever begin
            @(negedge sys_clk);
            if (bus.mem_we === 1'b1) begin
                wr_q.push_back({bus.mem_addr, bus.mem_wdata});
                wr_cyc_q.push_back(cyc);
            end
            if (load_ok === 1'b1) begin
                ok_cnt++;
                ok_cyc = cyc;
            end
            if (load_err === 1'b1) err_cnt++;
            if (bus.tx_start === 1'b1 && !tx_prev) begin
                tx_cnt++;
                tx_byte = bus.tx_data;
            end
            if (cpu_hold === 1'b0 && hold_prev) hold_fall_cyc = cyc;
            hold_prev = (cpu_hold === 1'b1);
            tx_prev   = (bus.tx_start === 1'b1);
        end
    end

    // UART transmitter model: raises tx_done a few cycles into a request, drops it after release
    initial begin
        int tx_wait = 0;
        bus.tx_done = 1'b0;
        forever begin
            @(negedge sys_clk);
            if (bus.tx_start === 1'b1 && !bus.tx_done) begin
                tx_wait++;
                if (tx_wait >= 3) begin
                    bus.tx_done = 1'b1;
                    tx_wait     = 0;
                end
            end else if (bus.tx_start !== 1'b1 && bus.tx_done) begin
                bus.tx_done   = 1'b0;
                done_fall_cyc = cyc + 1;
            end
        end
    end

    // driver tasks
    task automatic send_byte(input logic [7:0] b);
        @(negedge sys_clk);
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        last_rx_cyc  = cyc + 1;
        @(negedge sys_clk);
        bus.rx_valid = 1'b0;
    endtask

    task automatic send_frame();
        foreach (frm[i]) send_byte(frm[i]);
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (cpu_hold === 1'b1 && n < 400) begin
            @(negedge sys_clk);
            n++;
        end
        check({tag, "_hold_release"}, {31'd0, cpu_hold}, 32'd0);
        repeat (3) @(negedge sys_clk);
    endtask

    task automatic check_result(input string tag, input int w0, input int ok0, input int err0,
                                input int tx0, input int exp_ok, input int exp_err,
                                input logic [7:0] exp_byte);
        int nexp = exp_q.size();
        check({tag, "_nwrites"}, wr_q.size() - w0, nexp);
        for (int i = 0; i < nexp && (w0 + i) < wr_q.size(); i++) begin
            check({tag, "_write"}, {20'd0, wr_q[w0 + i]}, {20'd0, exp_q[i]});
        end
        exp_q.delete();
        check({tag, "_load_ok"}, ok_cnt - ok0, exp_ok);
        check({tag, "_load_err"}, err_cnt - err0, exp_err);
        check({tag, "_ntx"}, tx_cnt - tx0, 1);
        check({tag, "_tx_byte"}, {24'd0, tx_byte}, {24'd0, exp_byte});
    endtask

    int w0, ok0, err0, tx0, csum_cyc;

    task automatic snap();
        w0   = wr_q.size();
        ok0  = ok_cnt;
        err0 = err_cnt;
        tx0  = tx_cnt;
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_mem_we"}, {31'd0, bus.mem_we}, 32'd0);
        check({tag, "_mem_addr"}, {28'd0, bus.mem_addr}, 32'd0);
        check({tag, "_mem_wdata"}, {24'd0, bus.mem_wdata}, 32'd0);
        check({tag, "_tx_start"}, {31'd0, bus.tx_start}, 32'd0);
        check({tag, "_tx_data"}, {24'd0, bus.tx_data}, 32'd0);
        check({tag, "_cpu_hold"}, {31'd0, cpu_hold}, 32'd0);
        check({tag, "_load_ok"}, {31'd0, load_ok}, 32'd0);
        check({tag, "_load_err"}, {31'd0, load_err}, 32'd0);
        check({tag, "_state"}, {29'd0, dbg_state}, 32'd0);
    endtask

    initial begin
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        sys_rst      = 1'b1;
        repeat (3) @(negedge sys_clk);
        check_zero_outputs("reset");
        sys_rst = 1'b0;
        repeat (2) @(negedge sys_clk);

        // 3 bytes at 4: 03+04+11+22+33 = 6D, checksum 93
        snap();
        send_byte(8'h55);
        check("t1_hold_after_sync", {31'd0, cpu_hold}, 32'd1);
        frm = {8'h03, 8'h04, 8'h11, 8'h22, 8'h33, 8'h93};
        send_frame();
        csum_cyc = last_rx_cyc;
        wait_idle("t1");
        exp_q = {12'h411, 12'h522, 12'h633};
        check_result("t1", w0, ok0, err0, tx0, 1, 0, 8'h06);
        if (wr_q.size() >= w0 + 3) begin
            check("t1_first_write_cyc", wr_cyc_q[w0], csum_cyc);
            check("t1_second_write_cyc", wr_cyc_q[w0 + 1], csum_cyc + 1);
            check("t1_third_write_cyc", wr_cyc_q[w0 + 2], csum_cyc + 2);
        end else begin
            check("t1_write_cycles_present", wr_q.size() - w0, 3);
        end
        check("t1_load_ok_cyc", ok_cyc, csum_cyc + 3);
        check("t1_hold_fall_after_done", hold_fall_cyc, done_fall_cyc);

        // address wrap: 02+0F+AA+BB = 76, checksum 8A
        snap();
        frm = {8'h55, 8'h02, 8'h0F, 8'hAA, 8'hBB, 8'h8A};
        send_frame();
        wait_idle("t2");
        exp_q = {12'hFAA, 12'h0BB};
        check_result("t2", w0, ok0, err0, tx0, 1, 0, 8'h06);

        // full 16-byte payload at base A, data = index: 10+0A+78 = 92, checksum 6E
        snap();
        frm = {8'h55, 8'h10, 8'h0A};
        for (int i = 0; i < 16; i++) begin
            frm.push_back(8'(i));
            exp_q.push_back({4'(10 + i), 8'(i)});
        end
        frm.push_back(8'h6E);
        send_frame();
        wait_idle("t16");
        check_result("t16", w0, ok0, err0, tx0, 1, 0, 8'h06);

        // bad checksum: 01+00+7E+00 = 7F
        snap();
        frm = {8'h55, 8'h01, 8'h00, 8'h7E, 8'h00};
        send_frame();
        wait_idle("t3");
        check_result("t3", w0, ok0, err0, tx0, 0, 1, 8'h15);

        // zero count, then stray bytes while idle
        snap();
        frm = {8'h55, 8'h00};
        send_frame();
        wait_idle("t4a");
        check_result("t4a", w0, ok0, err0, tx0, 0, 1, 8'h15);
        snap();
        frm = {8'h03, 8'h04, 8'h11};
        send_frame();
        check("t4a_stray_hold", {31'd0, cpu_hold}, 32'd0);
        check("t4a_stray_writes", wr_q.size() - w0, 0);

        // count too large, trailing bytes land during the response
        snap();
        frm = {8'h55, 8'h11, 8'h04, 8'hAA};
        send_frame();
        wait_idle("t4b");
        check_result("t4b", w0, ok0, err0, tx0, 0, 1, 8'h15);

        // noise before sync, then reset after the first commit write
        snap();
        frm = {8'h00, 8'hAA};
        send_frame();
        check("t5_noise_hold", {31'd0, cpu_hold}, 32'd0);
        frm = {8'h55, 8'h03, 8'h04, 8'h11, 8'h22, 8'h33};
        send_frame();
        @(negedge sys_clk);
        bus.rx_valid = 1'b1;
        bus.rx_data  = 8'h93;
        @(negedge sys_clk);
        bus.rx_valid = 1'b0;
        check("t5_write0_seen", {31'd0, bus.mem_we}, 32'd1);
        sys_rst = 1'b1;
        @(negedge sys_clk);
        sys_rst = 1'b0;
        check_zero_outputs("t5_abort");
        repeat (30) @(negedge sys_clk);
        check("t5_nwrites", wr_q.size() - w0, 1);
        check("t5_ntx", tx_cnt - tx0, 0);
        check("t5_load_ok", ok_cnt - ok0, 0);
        check("t5_hold", {31'd0, cpu_hold}, 32'd0);

        // loader still works after the abort
        snap();
        frm = {8'h55, 8'h02, 8'h0F, 8'hAA, 8'hBB, 8'h8A};
        send_frame();
        wait_idle("post_rst");
        exp_q = {12'hFAA, 12'h0BB};
        check_result("post_rst", w0, ok0, err0, tx0, 1, 0, 8'h06);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
